// File: rtl/mult.sv
// Sequential unsigned 8x8 shift-and-add multiplier.
// One partial product is added per cycle. The product is published eight
// cycles after the start edge.
module mult (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  a_bi,
   input  logic [7:0]  b_bi,
   input  logic        start,
   output logic        busy_o,
   output logic [15:0] y_bo
);

   typedef enum logic {StIdle, StWork} state_e;

   state_e      state_q, state_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [15:0] acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [15:0] y_q, y_d;

   logic [15:0] pp;
   logic [15:0] sum;

   // Partial product for the current multiplier bit, and the running sum.
   always_comb begin
      pp  = b_q[cnt_q] ? ({8'd0, a_q} << cnt_q) : 16'd0;
      sum = acc_q + pp;
   end

   // Next-state logic: latch the operands on start, then accumulate one bit per cycle.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      y_d     = y_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a_bi;
               b_d     = b_bi;
               acc_d   = 16'd0;
               cnt_d   = 3'd0;
               busy_d  = 1'b1;
               state_d = StWork;
            end
         end
         StWork: begin
            acc_d = sum;
            cnt_d = cnt_q + 3'd1;
            // The last bit publishes the sum that includes its own partial product.
            if (cnt_q == 3'd7) begin
               y_d     = sum;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers. A synchronous reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         a_q     <= 8'd0;
         b_q     <= 8'd0;
         acc_q   <= 16'd0;
         cnt_q   <= 3'd0;
         busy_q  <= 1'b0;
         y_q     <= 16'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         y_q     <= y_d;
      end
   end

   assign busy_o = busy_q;
   assign y_bo   = y_q;

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult.
// A countdown model predicts busy_o and y_bo on every cycle. Directed
// scenarios add literal expectations, and randomized operations follow them.
module tb_mult;

   logic        clk;
   logic        reset;
   logic [7:0]  a_bi;
   logic [7:0]  b_bi;
   logic        start;
   logic        busy_o;
   logic [15:0] y_bo;

   int n_checks = 0;
   int n_pass   = 0;

   mult dut (
      .clk    (clk),
      .reset  (reset),
      .a_bi   (a_bi),
      .b_bi   (b_bi),
      .start  (start),
      .busy_o (busy_o),
      .y_bo   (y_bo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: an accepted start yields a*b exactly eight edges later.
   bit          m_valid = 0;
   bit          m_busy  = 0;
   int          m_rem   = 0;
   logic [15:0] m_y     = 16'd0;
   int unsigned m_pend  = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_valid = 1;
         m_busy  = 0;
         m_rem   = 0;
         m_y     = 16'd0;
      end else if (m_valid) begin
         if (!m_busy) begin
            if (start) begin
               m_busy = 1;
               m_rem  = 8;
               m_pend = int'(a_bi) * int'(b_bi);
            end
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 0;
               m_y    = m_pend[15:0];
            end
         end
      end
      #1;
      if (m_valid) begin
         check("model_busy", 32'(busy_o), 32'(m_busy));
         check("model_y", 32'(y_bo), 32'(m_y));
      end
   end

   // Launch one operation from idle, scramble the operands while it runs, and
   // measure the latency until busy_o falls.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp);
      int cycles = 0;
      a_bi  = a;
      b_bi  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cycles < 20) begin
         a_bi = 8'($urandom);
         b_bi = 8'($urandom);
         @(negedge clk);
         cycles++;
         if (!busy_o) break;
      end
      check("op_latency", 32'(cycles), 32'd8);
      check("op_product", 32'(y_bo), 32'(exp));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      a_bi  = 8'd0;
      b_bi  = 8'd0;
      @(negedge clk);
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_y", 32'(y_bo), 32'd0);
      reset = 1'b0;

      // Square 8
      a_bi  = 8'd8;
      b_bi  = 8'd8;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_bi  = 8'd0;
      b_bi  = 8'd0;
      check("sq8_busy_k", 32'(busy_o), 32'd1);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("sq8_busy_run", 32'(busy_o), 32'd1);
      end
      @(negedge clk);
      check("sq8_done_busy", 32'(busy_o), 32'd0);
      check("sq8_y", 32'(y_bo), 32'd64);
      repeat (3) @(negedge clk);
      check("sq8_y_hold", 32'(y_bo), 32'd64);

      // Corner products
      run_op(8'd255, 8'd255, 65025);
      run_op(8'd0, 8'd77, 0);
      run_op(8'd13, 8'd11, 143);
      run_op(8'd1, 8'd200, 200);

      // Start while busy is ignored
      a_bi  = 8'd3;
      b_bi  = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      a_bi  = 8'd9;
      b_bi  = 8'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_start_y", 32'(y_bo), 32'd9);
      check("busy_start_idle", 32'(busy_o), 32'd0);
      @(negedge clk);
      check("busy_start_ignored", 32'(busy_o), 32'd0);

      // Reset mid-operation
      a_bi  = 8'd100;
      b_bi  = 8'd100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_y", 32'(y_bo), 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_publish", 32'(y_bo), 32'd0);
      end

      // Back-to-back with start held high
      a_bi  = 8'd2;
      b_bi  = 8'd3;
      start = 1'b1;
      @(negedge clk);
      a_bi  = 8'd4;
      b_bi  = 8'd5;
      repeat (7) @(negedge clk);
      check("b2b_busy_k7", 32'(busy_o), 32'd1);
      @(negedge clk);
      check("b2b_y1", 32'(y_bo), 32'd6);
      check("b2b_gap", 32'(busy_o), 32'd0);
      @(negedge clk);
      check("b2b_restart", 32'(busy_o), 32'd1);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("b2b_y2", 32'(y_bo), 32'd20);
      check("b2b_idle", 32'(busy_o), 32'd0);

      // Operand change after start
      run_op(8'd6, 8'd7, 42);

      // Randomized operations with gaps and spurious starts while busy
      for (int n = 0; n < 60; n++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (n % 5 == 0) rb = ra;
         run_op(ra, rb, int'(ra) * int'(rb));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            a_bi  = 8'($urandom);
            b_bi  = 8'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            a_bi  = 8'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (10) @(negedge clk);
         end
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
